// File: rtl/bulk_in_ctrl_pkg.sv
// Shared definitions for the bulk IN sequencer: USB PID codes, FSM state
// encoding and a helper that maps a data toggle to its DATAx PID.
// Optional feature macro: BULK_IN_HALT_EN (adds the STALL/HALT path).
package bulk_in_ctrl_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
`ifdef BULK_IN_HALT_EN
  localparam logic [3:0] PID_STALL = 4'b1110;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_NAK  = 3'd2,
    S_DATA = 3'd3,
    S_ZLP  = 3'd4,
    S_WAIT = 3'd5
`ifdef BULK_IN_HALT_EN
    ,
    S_HALT = 3'd6
`endif
  } state_t;

  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/bulk_in_ctrl.sv
// bulk_in_ctrl: USB-clock-domain sequencer for NUM_EP bulk IN endpoint FIFOs.
// On each IN token addressed to one of its endpoints it answers with a
// DATA0/DATA1 packet (up to MAX_PKT_SIZE bytes), a ZLP or a NAK, and keeps
// the per-endpoint data toggle and pending-ZLP flag.
// Optional feature macro: BULK_IN_HALT_EN adds ep_halt_i and the STALL reply.
//
// Ports:
//   clock, reset_n        USB clock, asynchronous active-low reset
//   usb_in_tok_i/_ep_i    IN token strobe and its endpoint number
//   usb_ack_i             host ACK strobe
//   usb_timeout_i         no-handshake strobe
//   ep_clr_toggle_i       per-EP toggle (and pending ZLP) clear
//   ep_has_data_i         per-EP FIFO has_data
//   ep_xfer_o             per-EP transaction-in-progress
//   ep_t*_i / ep_tready_o per-EP AXIS source
//   ep_halt_i             per-EP halt (BULK_IN_HALT_EN only)
//   tx_hsk_o, tx_pid_o    handshake strobe and PID towards the TX encoder
//   tx_t*                 TX payload stream
//   busy_o                state != IDLE
module bulk_in_ctrl
  import bulk_in_ctrl_pkg::*;
#(
  parameter int unsigned NUM_EP       = 2,
  parameter int unsigned EP_BASE      = 1,
  parameter int unsigned MAX_PKT_SIZE = 512
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  usb_in_tok_i,
  input  logic [3:0]            usb_in_ep_i,
  input  logic                  usb_ack_i,
  input  logic                  usb_timeout_i,
  input  logic [NUM_EP-1:0]     ep_clr_toggle_i,
  input  logic [NUM_EP-1:0]     ep_has_data_i,
  output logic [NUM_EP-1:0]     ep_xfer_o,
  input  logic [NUM_EP-1:0]     ep_tvalid_i,
  output logic [NUM_EP-1:0]     ep_tready_o,
  input  logic [NUM_EP-1:0]     ep_tlast_i,
  input  logic [8*NUM_EP-1:0]   ep_tdata_i,
`ifdef BULK_IN_HALT_EN
  input  logic [NUM_EP-1:0]     ep_halt_i,
`endif
  output logic                  tx_hsk_o,
  output logic [3:0]            tx_pid_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  output logic                  tx_tlast_o,
  output logic [7:0]            tx_tdata_o,
  output logic                  busy_o
);

  localparam int unsigned IW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int unsigned CW = $clog2(MAX_PKT_SIZE + 1);

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_idx;
  logic [NUM_EP-1:0]   r_toggle;
  logic [NUM_EP-1:0]   r_zlp_pend;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_pid;
  logic                r_was_zlp;

  // Token decode: one extra bit so endpoint numbers below EP_BASE wrap
  // to a large offset and fail the range check.
  logic [4:0]          w_ep_off;
  logic                w_tok_hit;
  logic [IW-1:0]       w_tok_idx;

  assign w_ep_off  = {1'b0, usb_in_ep_i} - 5'(EP_BASE);
  assign w_tok_hit = usb_in_tok_i && ({1'b0, usb_in_ep_i} >= 5'(EP_BASE))
                     && (w_ep_off < 5'(NUM_EP));
  assign w_tok_idx = w_ep_off[IW-1:0];

  // Source mux by registered index.
  logic [7:0]          w_tdata_arr [NUM_EP];
  logic                w_sel_tvalid;
  logic                w_cnt_max;
  logic                w_last;
  logic                w_beat;
  logic                w_ack_hit;
  logic                w_xfer_st;

  for (genvar g = 0; g < NUM_EP; g++) begin : g_tdata
    assign w_tdata_arr[g] = ep_tdata_i[8*g +: 8];
  end

  assign w_sel_tvalid = ep_tvalid_i[r_idx];
  assign w_cnt_max    = (r_cnt == CW'(MAX_PKT_SIZE - 1));
  assign w_last       = ep_tlast_i[r_idx] | w_cnt_max;
  assign w_beat       = (r_state == S_DATA) && w_sel_tvalid && tx_tready_i;
  assign w_ack_hit    = (r_state == S_WAIT) && usb_ack_i;
  assign w_xfer_st    = (r_state == S_SEL) || (r_state == S_DATA) ||
                        (r_state == S_ZLP) || (r_state == S_WAIT);
  assign tx_pid_o     = r_pid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    tx_hsk_o    = 1'b0;
    tx_tvalid_o = 1'b0;
    tx_tlast_o  = 1'b0;
    tx_tdata_o  = '0;
    ep_tready_o = '0;
    ep_xfer_o   = '0;
    busy_o      = (r_state != S_IDLE);

    ep_xfer_o[r_idx] = w_xfer_st;

    case (r_state)
      S_IDLE: if (w_tok_hit) w_next = S_SEL;
      S_SEL: begin
`ifdef BULK_IN_HALT_EN
        if (ep_halt_i[r_idx])              w_next = S_HALT;
        else
`endif
        if (r_zlp_pend[r_idx])             w_next = S_ZLP;
        else if (ep_has_data_i[r_idx])     w_next = S_DATA;
        else                               w_next = S_NAK;
      end
      S_NAK: begin
        tx_hsk_o = 1'b1;
        w_next   = S_IDLE;
      end
`ifdef BULK_IN_HALT_EN
      S_HALT: begin
        tx_hsk_o = 1'b1;
        w_next   = S_IDLE;
      end
`endif
      S_DATA: begin
        tx_tvalid_o        = w_sel_tvalid;
        tx_tlast_o         = w_last;
        tx_tdata_o         = w_tdata_arr[r_idx];
        ep_tready_o[r_idx] = tx_tready_i;
        if (w_beat && w_last) w_next = S_WAIT;
      end
      S_ZLP: begin
        tx_tvalid_o = 1'b1;
        tx_tlast_o  = 1'b1;
        if (tx_tready_i) w_next = S_WAIT;
      end
      S_WAIT: if (usb_ack_i || usb_timeout_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_pid     <= '0;
      r_was_zlp <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_tok_hit) r_idx <= w_tok_idx;
      if (r_state == S_SEL) begin
        r_cnt     <= '0;
        r_was_zlp <= (w_next == S_ZLP);
        if (w_next == S_NAK)     r_pid <= PID_NAK;
`ifdef BULK_IN_HALT_EN
        else if (w_next == S_HALT) r_pid <= PID_STALL;
`endif
        else                     r_pid <= data_pid(r_toggle[r_idx]);
      end else if (w_beat) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Clear beats both the ACK flip and a ZLP-pending set in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_toggle   <= '0;
      r_zlp_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        if (ep_clr_toggle_i[i]) begin
          r_toggle[i]   <= 1'b0;
          r_zlp_pend[i] <= 1'b0;
        end else if (r_idx == IW'(i)) begin
          if (w_ack_hit) begin
            r_toggle[i] <= ~r_toggle[i];
            if (r_was_zlp) r_zlp_pend[i] <= 1'b0;
          end
          // Frame ended exactly on a full packet: the host needs a ZLP.
          if (w_beat && w_cnt_max && ep_tlast_i[i]) r_zlp_pend[i] <= 1'b1;
        end
      end
    end
  end

endmodule
